// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER_CMD,
        GAP,
        XFER_RSP,
        HOLD,
        DONE
    } spi_host_state_t;

    localparam logic [7:0] SPI_CMD_NOP  = 8'h00;
    localparam logic [7:0] SPI_CMD_COST = 8'h01;
    localparam int         SPI_BYTE_BITS = 8;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter and mode-0 SCK generator for the SPI host.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    input  logic toggle_en,
    output logic tick,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);
    assign rise = tick && toggle_en && !sck;
    assign fall = tick && toggle_en && sck;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (rise || fall)
                sck <= !sck;
        end
    end

endmodule

// File: rtl/spi_host_controller.sv
// SPI host: one command byte out (MSB-first), one response byte in (LSB-first).
// Optional abort port pair enabled by defining SPI_HOST_ABORT_EN.
module spi_host_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int GAP_HALF = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       SS,
    output logic       SCK,
`ifdef SPI_HOST_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    input  logic       MISO,
    output logic       MOSI
);

    localparam int XFER_HALVES = 2 * SPI_BYTE_BITS;
    localparam int HMAX = (GAP_HALF > XFER_HALVES) ? GAP_HALF : XFER_HALVES;
    localparam int HW = $clog2(HMAX);
    localparam logic [HW-1:0] XFER_LAST = HW'(XFER_HALVES - 1);
    localparam logic [HW-1:0] GAP_LAST  = HW'((GAP_HALF > 0) ? GAP_HALF - 1 : 0);

    spi_host_state_t state;
    logic [HW-1:0]   hcnt;
    logic [6:0]      tx_shift;
    logic [7:0]      rx_shift;
    logic            tick, rise, fall;
    logic            abort_hit;

`ifdef SPI_HOST_ABORT_EN
    assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
    assign abort_hit = 1'b0;
`endif

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (state != IDLE),
        .clr       ((state == IDLE) || abort_hit),
        .toggle_en ((state == XFER_CMD) || (state == XFER_RSP)),
        .tick      (tick),
        .sck       (SCK),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            SS       <= 1'b1;
            MOSI     <= 1'b0;
`ifdef SPI_HOST_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_HOST_ABORT_EN
            aborted  <= abort_hit;
`endif
            if (abort_hit) begin
                state <= IDLE;
                hcnt  <= '0;
                busy  <= 1'b0;
                SS    <= 1'b1;
                MOSI  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            tx_shift <= cmd[6:0];
                            MOSI     <= cmd[7];
                            SS       <= 1'b0;
                            busy     <= 1'b1;
                            hcnt     <= '0;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (tick)
                            state <= XFER_CMD;
                    end
                    XFER_CMD: begin
                        if (tick) begin
                            hcnt <= hcnt + 1'b1;
                            if (hcnt == XFER_LAST) begin
                                hcnt  <= '0;
                                MOSI  <= 1'b0;
                                state <= (GAP_HALF == 0) ? XFER_RSP : GAP;
                            end else if (fall) begin
                                MOSI     <= tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            hcnt <= hcnt + 1'b1;
                            if (hcnt == GAP_LAST) begin
                                hcnt  <= '0;
                                state <= XFER_RSP;
                            end
                        end
                    end
                    XFER_RSP: begin
                        if (rise)
                            rx_shift <= {MISO, rx_shift[7:1]};
                        if (tick) begin
                            hcnt <= hcnt + 1'b1;
                            if (hcnt == XFER_LAST) begin
                                hcnt  <= '0;
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            SS       <= 1'b1;
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        if (tick) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_host_controller.md
Name: spi_host_controller

Overview:
SPI initiator (host) for the digit-recognizer slave port. It runs one two-byte transaction per request: a command byte shifted out on MOSI, then a response byte captured from MISO. It drives SS, SCK and MOSI, generating SCK from clk via a divider. It is used on the host/test side to issue commands (e.g. cost request) and read back the digit or cost byte.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period; legal values ≥2.
GAP_HALF, 2, SCK-low half-periods between command byte and response byte; legal values ≥0.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
start  input  1  request a transaction; accepted only when busy=0
cmd  input  8  command byte; latched on the accepting edge
busy  output  1  high from the cycle after acceptance until return to IDLE
rx_valid  output  1  one-cycle pulse when rx_data is updated
rx_data  output  8  last received response byte
SS  output  1  slave select, active low
SCK  output  1  serial clock, mode 0 (idles low)
MOSI  output  1  host-to-slave data, MSB-first
MISO  input  1  slave-to-host data, LSB-first

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk. Reset values: SS=1, SCK=0, MOSI=0, busy=0, rx_valid=0, rx_data=8'h00, state=IDLE, all counters 0.
- Reset mid-transaction applies the reset values immediately. No rx_valid pulse is produced and no partial rx_data is kept.
- tick: the half-period counter runs 0..CLK_DIV-1 in every non-IDLE state and asserts tick at CLK_DIV-1, then wraps to 0. It clears on entry to each state.
- FSM states: IDLE, SETUP, XFER_CMD, GAP, XFER_RSP, HOLD, DONE.
- IDLE: when start=1, latch cmd into the tx shift register and go to SETUP.
- SETUP: SS=0, SCK=0, MOSI=cmd[7]. After 1 half-period, go to XFER_CMD.
- XFER_CMD: SCK toggles on every tick, for 16 half-periods.
  - Each falling edge except the last advances MOSI to the next lower bit.
  - MISO is ignored.
  - After the 8th falling edge, go to GAP.
- GAP: SCK=0, MOSI=0, SS=0, for GAP_HALF half-periods (0 means pass straight through). Then go to XFER_RSP.
- XFER_RSP: MOSI=0; SCK toggles for 16 half-periods.
  - MISO is sampled in the clk cycle where SCK goes 0→1: rx_shift <= {MISO, rx_shift[7:1]} (LSB arrives first).
  - After the 8th falling edge, go to HOLD.
- HOLD: SS=0, SCK=0 for 1 half-period, then go to DONE.
- DONE: SS=1, busy=1 for CLK_DIV cycles. In the first DONE cycle, rx_data <= rx_shift and rx_valid=1. Then go to IDLE.
- Latency: with start sampled at edge 0, SS falls at cycle 1. rx_valid is high at cycle 1+(34+GAP_HALF)·CLK_DIV. busy falls at cycle 1+(35+GAP_HALF)·CLK_DIV.
- start while busy=1 is ignored, not queued.
- start held high continuously starts a new transaction from the first IDLE cycle, so SS stays high for at least CLK_DIV+1 cycles between transactions.
- cmd changes after acceptance have no effect.
- rx_data holds its value between transactions.

Optional Feature:
SPI_HOST_ABORT_EN
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in any state other than IDLE/DONE forces, on the next edge: SS=1, SCK=0, MOSI=0, state IDLE, busy=0, aborted=1 for 1 cycle.
  - No rx_valid is produced and rx_data is unchanged.
  - abort in IDLE or DONE is ignored.
- Undefined: neither port exists and behaviour is exactly as above.

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_host_state_t;
  - constants SPI_CMD_NOP=8'h00, SPI_CMD_COST=8'h01;
  - SPI_BYTE_BITS=8.
- Sub-module spi_sck_gen:
  - half-period counter, tick, SCK register, rise/fall strobes;
  - enable and clear inputs from the FSM.
- The FSM, the tx/rx shift registers and the bit counter stay in spi_host_controller.

Test Plan:
- Reset (CLK_DIV=4, GAP_HALF=2): pulse n_rst low mid-cycle → SS=1, SCK=0, MOSI=0, busy=0, rx_valid=0, rx_data=8'h00 asynchronously.
- Basic transfer: start with cmd=8'hA5, MISO model returning 8'h3C LSB-first → MOSI sampled at SCK rises = 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid high only at cycle 145; busy low from cycle 149.
- Cost command against the slave model: cmd=SPI_CMD_COST, slave returns cost 8'h5E → rx_data=8'h5E; exactly 32 SCK edges per transaction.
- Busy rejection: pulse start with cmd=8'h01 at cycle 50 during an 8'hA5 transaction → single transaction only, MOSI pattern still 8'hA5.
- Reset mid XFER_RSP (cycle 100) → immediate idle outputs, rx_data=8'h00. A following cmd=8'h01 transaction with MISO 8'hFF gives rx_data=8'hFF.
- SPI_HOST_ABORT_EN: abort at cycle 40 → SS=1 next cycle, aborted pulses once, no rx_valid, rx_data keeps its previous value 8'h3C.
